padding_row_scheduler: RTL and testbench
========================================

PADDING_ROW_SCHEDULER -- requirements
Module: padding_row_scheduler

Interface
REQ-001 The block SHALL have parameter IMG_H, default 416, giving the unpadded image height in rows.
REQ-002 The block SHALL have parameter RW, default 9, giving the width of every row index.
REQ-003 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  Synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 start  input  1  One-cycle request to begin a frame.
REQ-006 abort  input  1  Cancels the frame in progress.
REQ-007 row_req  output  1  Requests unpadded input row row_idx from upstream.
REQ-008 row_idx  output  RW  Unpadded row index requested, range 0..IMG_H-1.
REQ-009 row_ack  input  1  Upstream has presented the requested row to the padding datapath.
REQ-010 pad_en  output  1  Enable for the padding datapath; high while busy.
REQ-011 slot_we  output  1  One-cycle write strobe into a line slot.
REQ-012 slot_sel  output  2  Target line slot, 0/1/2.
REQ-013 slot_zero  output  1  With slot_we, write an all-zero padded row instead of datapath output.
REQ-014 win_valid  output  1  A 3-row window is resident in the slots.
REQ-015 win_ready  input  1  Consumer accepts the window.
REQ-016 win_row  output  RW  Output row index of the window, 0..IMG_H-1.
REQ-017 win_base  output  2  Slot holding the top row of the window; rows follow as win_base, win_base+1, win_base+2 mod 3.
REQ-018 busy  output  1  High from frame start until DONE or abort.
REQ-019 done  output  1  One-cycle pulse at frame completion.

Function
REQ-020 The block SHALL implement states IDLE, LOAD, WIN and DONE.
REQ-021 Padded rows SHALL be numbered p = 0..IMG_H+1, with p=0 and p=IMG_H+1 being zero rows and p=k+1 being input row k; counter ld_p SHALL track the next padded row to load.
REQ-022 IDLE: when start=1, the block SHALL clear ld_p and the slot pointer to 0, set busy, and enter LOAD on the next cycle; start SHALL be ignored in all other states.
REQ-023 LOAD, zero row: the block SHALL take one cycle, assert no row_req, and pulse slot_we=1 with slot_zero=1 on the following cycle.
REQ-024 LOAD, data row: the block SHALL assert row_req with row_idx=ld_p-1 and hold both until row_ack=1, then pulse slot_we=1 with slot_zero=0 on the following cycle.
REQ-025 row_ack received while row_req=0 SHALL be ignored.
REQ-026 slot_sel SHALL equal ld_p mod 3 at write time; the slot pointer SHALL wrap 2 to 0.
REQ-027 After each write the block SHALL increment ld_p; if ld_p>=3 after the increment, it SHALL enter WIN, otherwise it SHALL stay in LOAD.
REQ-028 WIN: the block SHALL assert win_valid in the cycle after the slot_we pulse, with win_row=ld_p-3 and win_base=(ld_p-3) mod 3, all held stable until win_ready=1.
REQ-029 When win_valid and win_ready are both 1, win_valid SHALL drop the next cycle, and the block SHALL enter DONE if win_row==IMG_H-1, otherwise LOAD.
REQ-030 win_ready received while win_valid=0 SHALL be ignored.
REQ-031 DONE: the block SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-032 The block SHALL produce exactly IMG_H windows and IMG_H+2 slot writes per frame: 2 zero writes and IMG_H data writes.
REQ-033 When abort=1 in any non-IDLE state, the block SHALL enter IDLE next cycle, drop row_req, win_valid, slot_we and busy, and SHALL NOT pulse done.
REQ-034 If abort and start are both 1 in IDLE, the block SHALL take abort and remain in IDLE.
REQ-035 pad_en SHALL equal busy; the datapath SHALL be held cleared whenever the block is idle.

Reset
REQ-036 When reset=0 at a clock edge, the block SHALL enter IDLE, set ld_p and the slot pointer to 0, and drive all outputs to 0.
REQ-037 A reset during any state SHALL abandon the frame without a done pulse.
REQ-038 start SHALL be ignored in any cycle where reset=0.

Verification (IMG_H=4)
REQ-039 Full frame, with row_ack one cycle after each row_req and win_ready tied high: the bench SHALL observe slot writes p0..p5 with slot_zero pattern 1,0,0,0,0,1 and slot_sel 0,1,2,0,1,2; win_row 0,1,2,3 with win_base 0,1,2,0; row_idx 0..3; one done pulse; busy then low.
REQ-040 Backpressure, with win_ready held low for 5 cycles at win_row=1: the bench SHALL observe win_valid, win_row and win_base stable throughout, no row_req and no slot_we during the stall, and the frame completing normally.
REQ-041 Slow upstream, with row_ack delayed 3 cycles for row_idx=2: the bench SHALL observe row_req and row_idx=2 held for those 3 cycles and slot_we following the ack by exactly one cycle.
REQ-042 Abort while waiting for row_ack on row_idx=1: the bench SHALL observe IDLE next cycle with all outputs 0 and no done; a subsequent start SHALL restart from p0 with slot_sel 0.
REQ-043 Reset (reset=0) during WIN: the bench SHALL observe all outputs 0 at the next edge; stray row_ack and win_ready pulses and start while busy SHALL have no effect.

Source files
------------

// File: rtl/padding_row_scheduler_if.sv
// Handshake bundle between the padding row scheduler and its environment:
// upstream row fetch, line-slot write strobes and the 3-row window handoff.
interface padding_row_scheduler_if #(
    parameter int RW = 9
);
    logic          start;
    logic          abort;
    logic          row_req;
    logic [RW-1:0] row_idx;
    logic          row_ack;
    logic          pad_en;
    logic          slot_we;
    logic [1:0]    slot_sel;
    logic          slot_zero;
    logic          win_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [1:0]    win_base;
    logic          busy;
    logic          done;

    // Environment side: issues frame requests, acks rows, consumes windows.
    modport master (
        output start, abort, row_ack, win_ready,
        input  row_req, row_idx, pad_en, slot_we, slot_sel, slot_zero,
        input  win_valid, win_row, win_base, busy, done
    );

    // Scheduler side.
    modport slave (
        input  start, abort, row_ack, win_ready,
        output row_req, row_idx, pad_en, slot_we, slot_sel, slot_zero,
        output win_valid, win_row, win_base, busy, done
    );
endinterface

// File: rtl/padding_row_scheduler.sv
// Padding row scheduler: walks padded rows 0..IMG_H+1 (top/bottom rows are
// zero rows), fetches each data row from upstream, writes it into one of
// three rotating line slots and presents a 3-row window per output row.
module padding_row_scheduler #(
    parameter int IMG_H = 416,
    parameter int RW    = 9
) (
    input logic                    clk,
    input logic                    reset,
    padding_row_scheduler_if.slave bus
);
    localparam int PW = $clog2(IMG_H + 3);

    typedef enum logic [1:0] {IDLE, LOAD, WIN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] ld_p;
    logic [1:0]    ptr;
    logic          row_req;
    logic [RW-1:0] row_idx;
    logic          slot_we;
    logic [1:0]    slot_sel;
    logic          slot_zero;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [1:0]    win_base;
    logic          busy;
    logic          done;

    logic          zero_row;
    logic [1:0]    ptr_nxt;

    // Classify the padded row about to be loaded and the wrapped slot pointer.
    always_comb begin
        zero_row = (ld_p == '0) || (ld_p == PW'(IMG_H + 1));
        ptr_nxt  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    end

    // Frame sequencing with registered outputs. In LOAD, slot_we doubles as
    // the write-phase marker: the cycle it is high is the one that advances
    // ld_p and the slot pointer, so each padded row costs exactly one write.
    always_ff @(posedge clk) begin
        if (!reset || bus.abort) begin
            state     <= IDLE;
            ld_p      <= '0;
            ptr       <= '0;
            row_req   <= 1'b0;
            row_idx   <= '0;
            slot_we   <= 1'b0;
            slot_sel  <= '0;
            slot_zero <= 1'b0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_base  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        ld_p  <= '0;
                        ptr   <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (slot_we) begin
                        slot_we   <= 1'b0;
                        slot_zero <= 1'b0;
                        ld_p      <= ld_p + PW'(1);
                        ptr       <= ptr_nxt;
                        if (ld_p >= PW'(2)) begin
                            state     <= WIN;
                            win_valid <= 1'b1;
                            win_row   <= RW'(ld_p - PW'(2));
                            win_base  <= ptr_nxt;
                        end
                    end else if (row_req) begin
                        if (bus.row_ack) begin
                            row_req   <= 1'b0;
                            slot_we   <= 1'b1;
                            slot_zero <= 1'b0;
                            slot_sel  <= ptr;
                        end
                    end else if (zero_row) begin
                        slot_we   <= 1'b1;
                        slot_zero <= 1'b1;
                        slot_sel  <= ptr;
                    end else begin
                        row_req <= 1'b1;
                        row_idx <= RW'(ld_p - PW'(1));
                    end
                end
                WIN: begin
                    if (win_valid && bus.win_ready) begin
                        win_valid <= 1'b0;
                        if (win_row == RW'(IMG_H - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.row_req   = row_req;
    assign bus.row_idx   = row_idx;
    assign bus.pad_en    = busy;
    assign bus.slot_we   = slot_we;
    assign bus.slot_sel  = slot_sel;
    assign bus.slot_zero = slot_zero;
    assign bus.win_valid = win_valid;
    assign bus.win_row   = win_row;
    assign bus.win_base  = win_base;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_padding_row_scheduler.sv
// Bench for padding_row_scheduler with a 4-row image: a cycle table for a
// full frame, then directed sequences for stall, slow upstream, abort and
// reset mid-frame.
module tb_padding_row_scheduler;
    localparam int IMG_H = 4;
    localparam int RW    = 9;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    padding_row_scheduler_if #(.RW(RW)) bus ();

    padding_row_scheduler #(.IMG_H(IMG_H), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          row_req;
        logic [RW-1:0] row_idx;
        logic          pad_en;
        logic          slot_we;
        logic [1:0]    slot_sel;
        logic          slot_zero;
        logic          win_valid;
        logic [RW-1:0] win_row;
        logic [1:0]    win_base;
        logic          busy;
        logic          done;
    } outs_t;

    typedef struct {
        logic  rst_n;
        logic  start;
        logic  abort;
        logic  ack;
        logic  ready;
        outs_t exp;
    } vec_t;

    function automatic vec_t mk(int rst, int st, int ab, int ack, int rdy,
                                int rr, int idx, int we, int sel, int z,
                                int wv, int wr, int wb, int bsy, int dn);
        vec_t v;
        v.rst_n         = 1'(rst);
        v.start         = 1'(st);
        v.abort         = 1'(ab);
        v.ack           = 1'(ack);
        v.ready         = 1'(rdy);
        v.exp.row_req   = 1'(rr);
        v.exp.row_idx   = RW'(idx);
        v.exp.pad_en    = 1'(bsy);
        v.exp.slot_we   = 1'(we);
        v.exp.slot_sel  = 2'(sel);
        v.exp.slot_zero = 1'(z);
        v.exp.win_valid = 1'(wv);
        v.exp.win_row   = RW'(wr);
        v.exp.win_base  = 2'(wb);
        v.exp.busy      = 1'(bsy);
        v.exp.done      = 1'(dn);
        return v;
    endfunction

    function automatic outs_t get_outs();
        outs_t o;
        o.row_req   = bus.row_req;
        o.row_idx   = bus.row_idx;
        o.pad_en    = bus.pad_en;
        o.slot_we   = bus.slot_we;
        o.slot_sel  = bus.slot_sel;
        o.slot_zero = bus.slot_zero;
        o.win_valid = bus.win_valid;
        o.win_row   = bus.win_row;
        o.win_base  = bus.win_base;
        o.busy      = bus.busy;
        o.done      = bus.done;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame with a responsive upstream/consumer, optionally
    // stalling one window and delaying the ack of one row.
    task automatic run_frame(input string tag, input int stall_row, input int stall_len,
                             input int slow_idx, input int slow_len);
        int writes  = 0;
        int wins    = 0;
        int reqs    = 0;
        int stall   = 0;
        int slow    = 0;
        bit ack_prev = 1'b0;
        bit fin      = 1'b0;
        outs_t o;
        bus.row_ack   = 1'b0;
        bus.win_ready = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            o = get_outs();
            if (ack_prev) check({tag, "_we_after_ack"}, 64'(o.slot_we), 64'(1));
            ack_prev = 1'b0;
            if (o.slot_we) begin
                check({tag, "_slot_sel"}, 64'(o.slot_sel), 64'(writes % 3));
                check({tag, "_slot_zero"}, 64'(o.slot_zero),
                      64'((writes == 0 || writes == IMG_H + 1) ? 1 : 0));
                writes++;
            end
            bus.row_ack   = 1'b0;
            bus.win_ready = 1'b0;
            if ((stall > 0 && stall < stall_len) ||
                (stall == 0 && stall_len > 0 && o.win_valid && int'(o.win_row) == stall_row)) begin
                check({tag, "_stall_hold"},
                      64'({o.win_valid, o.win_row, o.win_base, o.row_req, o.slot_we}),
                      64'({1'b1, RW'(stall_row), 2'(stall_row % 3), 1'b0, 1'b0}));
                stall++;
            end else begin
                if (o.win_valid) begin
                    check({tag, "_win_row"}, 64'(o.win_row), 64'(wins));
                    check({tag, "_win_base"}, 64'(o.win_base), 64'(wins % 3));
                    wins++;
                    bus.win_ready = 1'b1;
                end
                if (o.row_req) begin
                    if (int'(o.row_idx) == slow_idx && slow < slow_len) begin
                        check({tag, "_slow_hold"}, 64'({o.row_req, o.row_idx, o.slot_we}),
                              64'({1'b1, RW'(slow_idx), 1'b0}));
                        slow++;
                    end else begin
                        check({tag, "_row_idx"}, 64'(o.row_idx), 64'(reqs));
                        reqs++;
                        bus.row_ack = 1'b1;
                        ack_prev    = 1'b1;
                    end
                end
            end
            if (o.done) begin
                check({tag, "_busy_at_done"}, 64'({o.busy, o.pad_en}), 64'(0));
                fin = 1'b1;
            end
            tick();
        end
        bus.row_ack   = 1'b0;
        bus.win_ready = 1'b0;
        check({tag, "_done_seen"}, 64'(fin), 64'(1));
        check({tag, "_done_pulse_end"}, 64'({bus.done, bus.busy}), 64'(0));
        check({tag, "_writes"}, 64'(writes), 64'(IMG_H + 2));
        check({tag, "_windows"}, 64'(wins), 64'(IMG_H));
        check({tag, "_requests"}, 64'(reqs), 64'(IMG_H));
        check({tag, "_stall_len"}, 64'(stall), 64'(stall_len));
        check({tag, "_slow_len"}, 64'(slow), 64'(slow_len));
    endtask

    vec_t vecs[$];

    initial begin
        bit hit;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.row_ack   = 1'b0;
        bus.win_ready = 1'b0;

        //             rst st ab ack rdy  rr idx we sel z wv wr wb bsy dn
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1,   0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1,   0, 1, 1, 2, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 1, 0, 2, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 1, 0, 2, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   1, 2, 0, 2, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1,   0, 2, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 2, 0, 0, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 2, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   1, 3, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1,   0, 3, 1, 1, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 3, 0, 1, 0, 1, 2, 2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 3, 0, 1, 0, 0, 2, 2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 3, 1, 2, 1, 0, 2, 2, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 3, 0, 2, 0, 1, 3, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 3, 0, 2, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1,   0, 3, 0, 2, 0, 0, 3, 0, 0, 0));

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst_n;
            bus.start     = vecs[i].start;
            bus.abort     = vecs[i].abort;
            bus.row_ack   = vecs[i].ack;
            bus.win_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d", i), 64'(get_outs()), 64'(vecs[i].exp));
        end
        bus.start     = 1'b0;
        bus.row_ack   = 1'b0;
        bus.win_ready = 1'b0;
        tick();

        run_frame("stall", 1, 5, -1, 0);
        run_frame("slow", -1, 0, 2, 3);

        // Abort while row 1 is outstanding, then restart from p0.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (bus.row_req && bus.row_idx == RW'(1)) begin
                hit = 1'b1;
            end else begin
                bus.row_ack   = bus.row_req;
                bus.win_ready = 1'b1;
                tick();
            end
        end
        check("abort_reach_row1", 64'(hit), 64'(1));
        bus.row_ack   = 1'b0;
        bus.win_ready = 1'b0;
        bus.abort     = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_outputs", 64'(get_outs()), 64'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_quiet", 64'(get_outs()), 64'(0));
        end
        run_frame("restart", -1, 0, -1, 0);

        // Abort and start together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_idle", 64'(get_outs()), 64'(0));

        // Reset during WIN, with stray inputs around it.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (bus.win_valid) begin
                hit = 1'b1;
            end else begin
                bus.row_ack = bus.row_req;
                tick();
            end
        end
        check("rst_reach_win", 64'(hit), 64'(1));
        bus.row_ack = 1'b1;
        bus.start   = 1'b1;
        tick();
        check("win_stray_inputs",
              64'({bus.win_valid, bus.win_row, bus.win_base, bus.row_req, bus.slot_we, bus.busy}),
              64'({1'b1, RW'(0), 2'd0, 1'b0, 1'b0, 1'b1}));
        bus.row_ack = 1'b0;
        bus.start   = 1'b0;
        reset       = 1'b0;
        tick();
        check("rst_in_win", 64'(get_outs()), 64'(0));
        bus.start = 1'b1;
        tick();
        check("start_during_rst", 64'(get_outs()), 64'(0));
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.row_ack   = 1'b1;
        bus.win_ready = 1'b1;
        tick();
        check("idle_stray_inputs", 64'(get_outs()), 64'(0));
        bus.row_ack   = 1'b0;
        bus.win_ready = 1'b0;
        tick();
        run_frame("post_rst", -1, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
